// File: rtl/quant_4x4_stream.sv
// H.264-style 4x4 forward quantiser, LANES coefficients per beat, 2-stage pipe.
// Ports: clk, reset (async, active-low); in_valid/in_ready, mode, qp, coef_in;
// out_valid/out_ready, quant_out, out_last, nz_count (valid on last beat only).
module quant_4x4_stream #(
   parameter int BIT_LENGTH = 15,
   parameter int LANES      = 4,
   parameter int F_INTRA    = 10923,
   parameter int F_INTER    = 5461
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          mode,
   input  logic [5:0]                    qp,
   input  logic [LANES*(BIT_LENGTH+1)-1:0] coef_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*(BIT_LENGTH+1)-1:0] quant_out,
   output logic                          out_last,
   output logic [4:0]                    nz_count
);

   localparam int W  = BIT_LENGTH + 1;
   localparam int NB = 16 / LANES;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int PW = W + 14;
   localparam int SW = W + 24;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

   logic [BW-1:0]            cnt;
   logic                     blk_mode;
   logic [5:0]               blk_qp;
   logic                     s1_valid;
   logic                     s1_last;
   logic                     s1_mode;
   logic [3:0]               s1_qdiv;
   logic [LANES-1:0]         s1_neg;
   logic [LANES-1:0][PW-1:0] s1_prod;
   logic                     s2_valid;
   logic                     s2_last;
   logic [4:0]               blk_nz;

   logic                     advance;
   logic                     accept;
   logic [5:0]               qp_clip;
   logic [5:0]               eff_qp;
   logic                     eff_mode;
   logic [3:0]               qdiv;
   logic [2:0]               qmod;
   logic [LANES-1:0]         nxt_neg;
   logic [LANES-1:0][PW-1:0] nxt_prod;
   logic [LANES*W-1:0]       nxt_q;
   logic [4:0]               beat_nz;

   function automatic logic [13:0] mf_of(input logic [3:0] p,
                                         input logic [2:0] m);
      logic [13:0] mf;
      mf = 14'd0;
      // p[2] = row parity, p[0] = column parity
      unique case (1'b1)
         (!p[2] && !p[0]): begin
            case (m)
               3'd0:    mf = 14'd13107;
               3'd1:    mf = 14'd11916;
               3'd2:    mf = 14'd10082;
               3'd3:    mf = 14'd9362;
               3'd4:    mf = 14'd8192;
               default: mf = 14'd7282;
            endcase
         end
         (p[2] && p[0]): begin
            case (m)
               3'd0:    mf = 14'd5243;
               3'd1:    mf = 14'd4660;
               3'd2:    mf = 14'd4194;
               3'd3:    mf = 14'd3647;
               3'd4:    mf = 14'd3355;
               default: mf = 14'd2893;
            endcase
         end
         (p[2] ^ p[0]): begin
            case (m)
               3'd0:    mf = 14'd8066;
               3'd1:    mf = 14'd7490;
               3'd2:    mf = 14'd6554;
               3'd3:    mf = 14'd5825;
               3'd4:    mf = 14'd5243;
               default: mf = 14'd4559;
            endcase
         end
      endcase
      return mf;
   endfunction

   // Stage 2 empty or draining: whole pipe may shift
   assign advance   = !s2_valid || out_ready;
   assign in_ready  = advance && reset;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign out_last  = s2_last;
   assign nz_count  = (s2_valid && s2_last) ? blk_nz : 5'd0;

   // First beat of a block uses live mode/qp; later beats use latched copy
   assign qp_clip  = (qp > 6'd51) ? 6'd51 : qp;
   assign eff_qp   = (cnt == '0) ? qp_clip : blk_qp;
   assign eff_mode = (cnt == '0) ? mode : blk_mode;
   assign qdiv     = 4'(eff_qp / 6'd6);
   assign qmod     = 3'(eff_qp % 6'd6);

   always_comb begin : s1_comb
      logic [W-1:0] x;
      logic [W-1:0] ax;
      logic [3:0]   pos;
      nxt_neg  = '0;
      nxt_prod = '0;
      x        = '0;
      ax       = '0;
      pos      = '0;
      for (int k = 0; k < LANES; k++) begin
         x   = coef_in[k*W +: W];
         // unsigned magnitude keeps -2^BIT_LENGTH exact
         ax  = x[W-1] ? (~x + 1'b1) : x;
         pos = 4'(int'(cnt) * LANES + k);
         nxt_neg[k]  = x[W-1];
         nxt_prod[k] = PW'(ax) * PW'(mf_of(pos, qmod));
      end
   end

   always_comb begin : s2_comb
      logic [14:0]   fb;
      logic [SW-1:0] f_sh;
      logic [SW-1:0] sum;
      logic [W-1:0]  mag;
      fb      = s1_mode ? 15'(F_INTRA) : 15'(F_INTER);
      f_sh    = SW'(fb) << s1_qdiv;
      sum     = '0;
      mag     = '0;
      nxt_q   = '0;
      beat_nz = '0;
      for (int k = 0; k < LANES; k++) begin
         sum = SW'(s1_prod[k]) + f_sh;
         mag = W'(sum >> (5'd15 + 5'(s1_qdiv)));
         nxt_q[k*W +: W] = s1_neg[k] ? (~mag + 1'b1) : mag;
         if (mag != '0) beat_nz = beat_nz + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         blk_mode  <= 1'b0;
         blk_qp    <= '0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_mode   <= 1'b0;
         s1_qdiv   <= '0;
         s1_neg    <= '0;
         s1_prod   <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         quant_out <= '0;
         blk_nz    <= '0;
      end else begin
         if (accept) begin
            cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
            if (cnt == '0) begin
               blk_mode <= mode;
               blk_qp   <= qp_clip;
            end
         end
         if (advance) begin
            s1_valid <= accept;
            s1_last  <= accept && (cnt == LAST_BEAT);
            if (accept) begin
               s1_mode <= eff_mode;
               s1_qdiv <= qdiv;
               s1_neg  <= nxt_neg;
               s1_prod <= nxt_prod;
            end
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            if (s1_valid) quant_out <= nxt_q;
            // count restarts once the last beat of a block has left
            blk_nz <= ((s2_valid && s2_last) ? 5'd0 : blk_nz)
                    + (s1_valid ? beat_nz : 5'd0);
         end
      end
   end

endmodule

// File: tb/tb_quant_4x4_stream.sv
// Scoreboard bench for quant_4x4_stream (LANES=4, 16-bit coefficients).
// Directed levels, back-to-back timing, random stalls, mid-block reset.
module tb_quant_4x4_stream;

   localparam int LANES = 4;
   localparam int W     = 16;
   localparam int MF_A[6] = '{13107, 11916, 10082, 9362, 8192, 7282};
   localparam int MF_B[6] = '{5243, 4660, 4194, 3647, 3355, 2893};
   localparam int MF_C[6] = '{8066, 7490, 6554, 5825, 5243, 4559};

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [4:0]  nz;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        mode;
   logic [5:0]  qp;
   logic [63:0] coef_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] quant_out;
   logic        out_last;
   logic [4:0]  nz_count;

   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   int   cyc    = 0;
   bit   rand_rdy = 1'b0;
   exp_t exp_q[$];
   int   acc_cyc[$];
   int   xfer_cyc[$];

   quant_4x4_stream dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .qp        (qp),
      .coef_in   (coef_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quant_out (quant_out),
      .out_last  (out_last),
      .nz_count  (nz_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_lvl(int x, int pos, bit m, int q);
      int qc, qd, qm, row, col;
      longint ax, mf, f, l;
      qc  = (q > 51) ? 51 : q;
      qd  = qc / 6;
      qm  = qc % 6;
      row = pos / 4;
      col = pos % 4;
      if (row % 2 == 0 && col % 2 == 0) mf = MF_A[qm];
      else if (row % 2 == 1 && col % 2 == 1) mf = MF_B[qm];
      else mf = MF_C[qm];
      ax = (x < 0) ? -longint'(x) : longint'(x);
      f  = longint'(m ? 10923 : 5461) << qd;
      l  = (ax * mf + f) >> (15 + qd);
      return (x < 0) ? -int'(l) : int'(l);
   endfunction

   function automatic int rnd_coef();
      logic signed [15:0] v;
      case ($urandom_range(0, 4))
         0:       return 0;
         1:       return int'($urandom_range(0, 40)) - 20;
         2:       return -32768;
         default: begin
            v = 16'($urandom);
            return int'(v);
         end
      endcase
   endfunction

   // Output monitor: head of queue must be on the bus whenever valid.
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
               chk("quant_out", quant_out, exp_q[0].data);
               chk("out_last", 64'(out_last), 64'(exp_q[0].last));
               chk("nz_count", 64'(nz_count), 64'(exp_q[0].nz));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  xfer_cyc.push_back(cyc);
               end
            end
         end else begin
            chk("nz_idle", 64'(nz_count), 64'd0);
         end
      end
   end

   // out_ready: held high, or 50% random when rand_rdy is set
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send_beat(input logic [63:0] d, input logic m,
                            input logic [5:0] q, input exp_t e);
      bit got;
      bit acc;
      got      = 1'b0;
      in_valid = 1'b1;
      coef_in  = d;
      mode     = m;
      qp       = q;
      for (int t = 0; t < 1000 && !got; t++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) acc_cyc.push_back(cyc);
         @(posedge clk);
         if (acc) begin
            exp_q.push_back(e);
            got = 1'b1;
         end
         #1;
      end
      if (!got) chk("accept_timeout", 64'(in_ready), 64'd1);
   endtask

   task automatic send_block(input bit m, input int q, input int c[16],
                             input int lv[16]);
      int   nz;
      exp_t e;
      logic [63:0] d;
      nz = 0;
      for (int p = 0; p < 16; p++) if (lv[p] != 0) nz++;
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < LANES; k++) begin
            d[k*W +: W]      = 16'(c[b*LANES + k]);
            e.data[k*W +: W] = 16'(lv[b*LANES + k]);
         end
         e.last = (b == 3);
         e.nz   = (b == 3) ? 5'(nz) : 5'd0;
         // non-first beats carry junk mode/qp that must be ignored
         send_beat(d, (b == 0) ? m : 1'($urandom),
                   (b == 0) ? 6'(q) : 6'($urandom), e);
      end
      in_valid = 1'b0;
   endtask

   task automatic fill_model(input bit m, input int q, input int c[16],
                             output int lv[16]);
      for (int p = 0; p < 16; p++) lv[p] = model_lvl(c[p], p, m, q);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic reset_state(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_data"}, quant_out, 64'd0);
      chk({tag, "_last"}, 64'(out_last), 64'd0);
      chk({tag, "_nz"}, 64'(nz_count), 64'd0);
   endtask

   initial begin
      int   c[16];
      int   lv[16];
      bit   m;
      int   q;
      exp_t e;
      logic [63:0] d;

      reset    = 1'b0;
      in_valid = 1'b0;
      mode     = 1'b0;
      qp       = '0;
      coef_in  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_state("rst");
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // inter qp0: small coef rounds to 0, pos1/pos5/pos13 levels
      c = '{default: 0};
      lv = '{default: 0};
      c[0] = 2;    lv[0] = 0;
      c[1] = 100;  lv[1] = 24;
      c[5] = 100;  lv[5] = 16;
      c[13] = -100; lv[13] = -16;
      send_block(1'b0, 0, c, lv);
      // intra qp0: same small coef rounds to 1
      c = '{default: 0};
      lv = '{default: 0};
      c[0] = 2;    lv[0] = 1;
      send_block(1'b1, 0, c, lv);
      // extremes: max positive and most negative input
      c = '{default: 0};
      lv = '{default: 0};
      c[0] = 32767;   lv[0] = 13106;
      c[10] = -32768; lv[10] = -13107;
      send_block(1'b0, 0, c, lv);
      // qp=28, qp/6 = 4 shift
      c = '{default: 0};
      lv = '{default: 0};
      c[0] = 200;  lv[0] = 3;
      send_block(1'b0, 28, c, lv);
      // qp=60 clamps to 51
      for (int p = 0; p < 16; p++) c[p] = rnd_coef();
      c[0] = 32767;
      fill_model(1'b1, 51, c, lv);
      send_block(1'b1, 60, c, lv);
      wait_drain();

      // back-to-back blocks with out_ready high
      @(posedge clk);
      #1;
      acc_cyc.delete();
      xfer_cyc.delete();
      for (int b = 0; b < 2; b++) begin
         for (int p = 0; p < 16; p++) c[p] = rnd_coef();
         m = 1'(b);
         q = 6 * b + 13;
         fill_model(m, q, c, lv);
         send_block(m, q, c, lv);
      end
      wait_drain();
      chk("b2b_beats", 64'(xfer_cyc.size()), 64'd8);
      if (xfer_cyc.size() == 8 && acc_cyc.size() == 8) begin
         chk("b2b_in_span", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
         chk("b2b_out_span", 64'(xfer_cyc[7] - xfer_cyc[0]), 64'd7);
         chk("latency", 64'(xfer_cyc[0] - acc_cyc[0]), 64'd2);
      end

      // 100 random blocks under random backpressure
      @(posedge clk);
      #1;
      rand_rdy = 1'b1;
      for (int b = 0; b < 100; b++) begin
         for (int p = 0; p < 16; p++) c[p] = rnd_coef();
         m = 1'($urandom);
         q = int'($urandom_range(0, 63));
         fill_model(m, q, c, lv);
         send_block(m, q, c, lv);
      end
      rand_rdy = 1'b0;
      wait_drain();

      // reset after two beats of a block
      @(posedge clk);
      #1;
      for (int b = 0; b < 2; b++) begin
         d = {4{16'(1000 + b)}};
         e.data = '0;
         e.last = 1'b0;
         e.nz   = '0;
         send_beat(d, 1'b1, 6'd3, e);
      end
      in_valid = 1'b0;
      reset    = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset_state("midrst");
      @(negedge clk);
      reset_state("midrst2");
      @(posedge clk);
      #1 reset = 1'b1;
      for (int p = 0; p < 16; p++) c[p] = 100 * (p + 1) - 700;
      fill_model(1'b0, 20, c, lv);
      send_block(1'b0, 20, c, lv);
      wait_drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
